// File: rtl/pma_rx.sv
// 100BASE-X PMA receive: NRZI-to-NRZ decode toward the PCS plus the link monitor
// that qualifies PMD signal detect with a stabilisation timer and a clock watchdog.
module pma_rx #(
    parameter int STABILIZE_CYCLES = 41250,
    parameter int WDOG_CYCLES      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] nrzi,
    input  logic [1:0] nrzi_valid,
    input  logic       signal_status,
    output logic [1:0] data,
    output logic [1:0] data_valid,
    output logic       link_status,
    output logic [1:0] link_state
);

    typedef enum logic [1:0] {
        LINK_DOWN  = 2'd0,
        HYSTERESIS = 2'd1,
        LINK_UP    = 2'd2
    } state_t;

    localparam int CW = $clog2(STABILIZE_CYCLES + 1);
    localparam int WW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [CW-1:0] STAB_L  = CW'(STABILIZE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [WW-1:0] WDOG_L  = WW'(WDOG_CYCLES);
    localparam logic [WW-1:0] WD_ONE  = WW'(1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [WW-1:0] wd, wd_nxt, wd_inc;
    logic          last;
    logic          idle;

    assign link_state = state;
    assign idle       = (nrzi_valid == 2'd0);

    // Both counters saturate rather than wrap.
    assign cnt_inc = (cnt == STAB_L) ? cnt : cnt + CNT_ONE;
    assign wd_inc  = (&wd) ? wd : wd + WD_ONE;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wd_nxt    = '0;
        case (state)
            LINK_DOWN: begin
                if (signal_status) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (STABILIZE_CYCLES == 1) ? LINK_UP : HYSTERESIS;
                end
            end
            HYSTERESIS: begin
                if (!signal_status) begin
                    state_nxt = LINK_DOWN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == STAB_L) state_nxt = LINK_UP;
                end
            end
            LINK_UP: begin
                wd_nxt = idle ? wd_inc : '0;
                // Signal loss and watchdog expiry on one edge give a single drop.
                if (!signal_status ||
                    ((WDOG_CYCLES != 0) && idle && (wd_inc == WDOG_L))) begin
                    state_nxt = LINK_DOWN;
                    cnt_nxt   = '0;
                    wd_nxt    = '0;
                end
            end
            default: begin
                state_nxt = LINK_DOWN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LINK_DOWN;
            cnt         <= '0;
            wd          <= '0;
            link_status <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wd          <= wd_nxt;
            link_status <= (state_nxt == LINK_UP);
        end
    end

    // NRZI decode: a 1 is a transition relative to the previous line bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= 2'b00;
            data_valid <= 2'd0;
            last       <= 1'b0;
        end else begin
            case (nrzi_valid)
                2'd0: begin
                    data       <= 2'b00;
                    data_valid <= 2'd0;
                end
                2'd1: begin
                    data       <= {nrzi[1] ^ last, 1'b0};
                    data_valid <= 2'd1;
                    last       <= nrzi[1];
                end
                default: begin
                    data       <= {nrzi[1] ^ last, nrzi[0] ^ nrzi[1]};
                    data_valid <= 2'd2;
                    last       <= nrzi[0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pma_rx.sv
// Bench for pma_rx: directed decode table, hand-written link-monitor sequences,
// then random traffic against a bit-stream / run-length reference model.
module tb_pma_rx;

    localparam int STAB = 4;
    localparam int WDOG = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] nrzi = 2'b00;
    logic [1:0] nrzi_valid = 2'd0;
    logic       signal_status = 1'b0;
    logic [1:0] data;
    logic [1:0] data_valid;
    logic       link_status;
    logic [1:0] link_state;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic       m_last;
    logic [1:0] m_data;
    logic [1:0] m_dv;
    logic       m_link;
    int         m_run;
    int         m_idle;

    typedef struct {
        logic [1:0] n;
        logic [1:0] v;
        logic [1:0] exp_data;
        logic [1:0] exp_dv;
    } vec_t;

    vec_t vecs[8];

    pma_rx #(.STABILIZE_CYCLES(STAB), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .nrzi(nrzi),
        .nrzi_valid(nrzi_valid),
        .signal_status(signal_status),
        .data(data),
        .data_valid(data_valid),
        .link_status(link_status),
        .link_state(link_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b0;
        m_data = 2'b00;
        m_dv   = 2'd0;
        m_link = 1'b0;
        m_run  = 0;
        m_idle = 0;
    endtask

    // Decode as a stream of line bits (oldest first); link as run lengths.
    task automatic model_step(input logic s, input logic [1:0] n, input logic [1:0] v);
        int k;
        logic b;
        k = (v == 2'd0) ? 0 : (v == 2'd1) ? 1 : 2;
        m_data = 2'b00;
        for (int i = 0; i < k; i++) begin
            b = n[1-i];
            m_data[1-i] = b ^ m_last;
            m_last = b;
        end
        m_dv = 2'(k);
        if (!m_link) begin
            m_run = s ? ((m_run < STAB) ? m_run + 1 : m_run) : 0;
            if (m_run >= STAB) begin
                m_link = 1'b1;
                m_idle = 0;
            end
        end else if (!s) begin
            m_link = 1'b0;
            m_run  = 0;
            m_idle = 0;
        end else begin
            m_idle = (v != 2'd0) ? 0 : m_idle + 1;
            if (WDOG != 0 && m_idle >= WDOG) begin
                m_link = 1'b0;
                m_run  = 0;
                m_idle = 0;
            end
        end
    endtask

    function automatic logic [1:0] exp_state();
        if (m_link) return 2'd2;
        return (m_run > 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic cycle(input logic s, input logic [1:0] n, input logic [1:0] v);
        signal_status = s;
        nrzi          = n;
        nrzi_valid    = v;
        @(posedge clk);
        model_step(s, n, v);
        #1;
        check("data", 32'(data), 32'(m_data));
        check("data_valid", 32'(data_valid), 32'(m_dv));
        check("link_status", 32'(link_status), 32'(m_link));
        check("link_state", 32'(link_state), 32'(exp_state()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        check("reset_data", 32'(data), 32'd0);
        check("reset_dv", 32'(data_valid), 32'd0);
        check("reset_link", 32'(link_status), 32'd0);
        check("reset_state", 32'(link_state), 32'd0);
        rst_n = 1'b1;
    endtask

    // Reset asserted between edges must clear outputs without waiting for clk.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_async_data"}, 32'(data), 32'd0);
        check({tag, "_async_dv"}, 32'(data_valid), 32'd0);
        check({tag, "_async_link"}, 32'(link_status), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    // Hold signal_status high with live traffic for n edges, expecting a fixed link value.
    task automatic hold_high(input int n, input logic exp_link, input string tag);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 2'b01, 2'd2);
            check(tag, 32'(link_status), 32'(exp_link));
        end
    endtask

    initial begin
        int idle_burst;
        logic s;
        logic [1:0] v;

        vecs[0] = '{2'b10, 2'd2, 2'b11, 2'd2};
        vecs[1] = '{2'b10, 2'd1, 2'b10, 2'd1};
        vecs[2] = '{2'b00, 2'd0, 2'b00, 2'd0};
        vecs[3] = '{2'b01, 2'd2, 2'b11, 2'd2};
        vecs[4] = '{2'b11, 2'd2, 2'b00, 2'd2};
        vecs[5] = '{2'b01, 2'd1, 2'b10, 2'd1};
        vecs[6] = '{2'b01, 2'd2, 2'b01, 2'd2};
        vecs[7] = '{2'b11, 2'd3, 2'b00, 2'd2};

        model_reset();
        #12;
        do_reset();

        // directed decode table
        foreach (vecs[i]) begin
            cycle(1'b0, vecs[i].n, vecs[i].v);
            check("tbl_data", 32'(data), 32'(vecs[i].exp_data));
            check("tbl_dv", 32'(data_valid), 32'(vecs[i].exp_dv));
        end

        // idle /I/: line history ends in 1, so 01 repeated decodes to all ones
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 2'b01, 2'd2);
            check("idle_data", 32'(data), 32'b11);
        end

        // stabilisation interrupted, then full period
        hold_high(3, 1'b0, "stab_short");
        cycle(1'b0, 2'b01, 2'd2);
        check("stab_drop", 32'(link_status), 32'd0);
        hold_high(3, 1'b0, "stab_wait");
        hold_high(1, 1'b1, "stab_up");

        // signal loss drops link in one edge, then re-stabilise
        cycle(1'b0, 2'b01, 2'd2);
        check("sig_loss", 32'(link_status), 32'd0);
        hold_high(3, 1'b0, "restab_wait");
        hold_high(1, 1'b1, "restab_up");

        // watchdog: 15 idle then traffic holds link; 16 idle drops it
        for (int i = 0; i < 15; i++) cycle(1'b1, 2'b00, 2'd0);
        check("wd_15_idle", 32'(link_status), 32'd1);
        cycle(1'b1, 2'b10, 2'd1);
        check("wd_kick", 32'(link_status), 32'd1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 2'b00, 2'd0);
        check("wd_15_again", 32'(link_status), 32'd1);
        cycle(1'b1, 2'b00, 2'd0);
        check("wd_expire", 32'(link_status), 32'd0);
        cycle(1'b1, 2'b01, 2'd2);
        check("wd_rehyst", 32'(link_state), 32'd1);
        hold_high(2, 1'b0, "wd_restab_wait");
        hold_high(1, 1'b1, "wd_restab_up");

        // signal loss and watchdog expiry on the same edge
        for (int i = 0; i < 15; i++) cycle(1'b1, 2'b00, 2'd0);
        cycle(1'b0, 2'b00, 2'd0);
        check("wd_and_loss", 32'(link_state), 32'd0);

        // async reset mid-HYSTERESIS discards the count
        hold_high(2, 1'b0, "pre_rst_hyst");
        mid_reset("hyst");
        hold_high(3, 1'b0, "post_rst_wait");
        hold_high(1, 1'b1, "post_rst_up");
        mid_reset("up");
        hold_high(3, 1'b0, "post_rst2_wait");
        hold_high(1, 1'b1, "post_rst2_up");

        // randomized traffic against the model
        idle_burst = 0;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 99) < 97);
            if (idle_burst > 0) begin
                v = 2'd0;
                idle_burst--;
            end else begin
                v = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) < 4) idle_burst = $urandom_range(10, 20);
            end
            cycle(s, 2'($urandom), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
